// File: rtl/shader_pkg.sv
// Shared opcode/state types and decode helpers for the shader accumulator core.
package shader_pkg;

    localparam int OP_W  = 3;
    localparam int ARG_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_LDI  = 3'd1,
        OP_IN   = 3'd2,
        OP_OUT  = 3'd3,
        OP_ADD  = 3'd4,
        OP_JMP  = 3'd5,
        OP_JNZ  = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_FETCH2 = 3'd3,
        S_WAIT2  = 3'd4,
        S_EXEC   = 3'd5,
        S_HALTED = 3'd6
    } state_e;

    // Opcodes that carry a second (operand) byte.
    function automatic logic is_two_byte(input opcode_e op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JNZ);
    endfunction

endpackage

// File: rtl/shader_port_bank.sv
// Output port register bank; a write to an index with no matching port is dropped.
module shader_port_bank
    import shader_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int WIDTH  = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_we,
    input  logic [ARG_W-1:0]               i_idx,
    input  logic [WIDTH-1:0]               i_wdata,
    output logic [NPORTS-1:0][WIDTH-1:0]   o_port
);

    logic [NPORTS-1:0][WIDTH-1:0] r_port;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_port <= '0;
        end else if (i_we) begin
            // Indices >= NPORTS match no entry, which is exactly the drop behaviour.
            for (int i = 0; i < NPORTS; i++) begin
                if (i_idx == ARG_W'(i)) r_port[i] <= i_wdata;
            end
        end
    end

    assign o_port = r_port;

endmodule

// File: rtl/shader_core.sv
// Accumulator sequencer: fetches byte instructions over a strobe/ready memory
// handshake and executes them against NPORTS rx/tx ports.
module shader_core
    import shader_pkg::*;
#(
    parameter int              NPORTS   = 4,
    parameter int              WIDTH    = 8,
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic                          rx_enable,
    input  logic [NPORTS-1:0][WIDTH-1:0]  rx_port,
    output logic [NPORTS-1:0][WIDTH-1:0]  tx_port,
    output logic                          tx_halted,
    output logic [PC_W-1:0]               tx_pc,
    output logic                          mem_tx_strobe,
    output logic                          mem_tx_write,
    output logic [PC_W-1:0]               mem_tx_addr,
    input  logic [7:0]                    mem_rx_data,
    input  logic                          mem_rx_ready
);

    state_e            r_state, w_state_next;
    logic [PC_W-1:0]   r_pc;
    logic [WIDTH-1:0]  r_acc;
    logic [7:0]        r_ir;
    logic [7:0]        r_opnd;
    logic              r_halted;

    opcode_e           w_op;
    logic [ARG_W-1:0]  w_arg;
    logic [WIDTH-1:0]  w_rx_sel;
    logic [11:0]       w_jmp_full;
    logic [PC_W-1:0]   w_jmp_tgt;
    logic              w_strobe;
    logic              w_out_we;

    assign w_op       = opcode_e'(r_ir[7:5]);
    assign w_arg      = r_ir[4:0];
    assign w_jmp_full = {w_arg[3:0], r_opnd};
    assign w_jmp_tgt  = w_jmp_full[PC_W-1:0];

    // Ports beyond NPORTS read as zero.
    always_comb begin
        w_rx_sel = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (w_arg == ARG_W'(i)) w_rx_sel = rx_port[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_strobe     = 1'b0;
        w_out_we     = 1'b0;
        case (r_state)
            S_IDLE:   if (rx_enable) w_state_next = S_FETCH;
            S_FETCH: begin
                w_strobe     = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rx_ready)
                    w_state_next = is_two_byte(opcode_e'(mem_rx_data[7:5])) ? S_FETCH2 : S_EXEC;
            end
            S_FETCH2: begin
                w_strobe     = 1'b1;
                w_state_next = S_WAIT2;
            end
            S_WAIT2:  if (mem_rx_ready) w_state_next = S_EXEC;
            S_EXEC: begin
                w_out_we = (w_op == OP_OUT);
                if (w_op == OP_HALT) w_state_next = S_HALTED;
                else                 w_state_next = rx_enable ? S_FETCH : S_IDLE;
            end
            S_HALTED: w_state_next = S_HALTED;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_pc     <= RESET_PC;
            r_acc    <= '0;
            r_ir     <= '0;
            r_opnd   <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (mem_rx_ready) begin
                        r_ir <= mem_rx_data;
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                S_WAIT2: begin
                    if (mem_rx_ready) begin
                        r_opnd <= mem_rx_data;
                        r_pc   <= r_pc + PC_W'(1);
                    end
                end
                S_EXEC: begin
                    // A taken jump replaces the increment already applied during fetch.
                    case (w_op)
                        OP_LDI:  r_acc    <= WIDTH'(r_opnd);
                        OP_IN:   r_acc    <= w_rx_sel;
                        OP_ADD:  r_acc    <= r_acc + w_rx_sel;
                        OP_JMP:  r_pc     <= w_jmp_tgt;
                        OP_JNZ:  if (r_acc != '0) r_pc <= w_jmp_tgt;
                        OP_HALT: r_halted <= 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    shader_port_bank #(
        .NPORTS (NPORTS),
        .WIDTH  (WIDTH)
    ) u_port_bank (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_we    (w_out_we),
        .i_idx   (w_arg),
        .i_wdata (r_acc),
        .o_port  (tx_port)
    );

    assign tx_halted     = r_halted;
    assign tx_pc         = r_pc;
    assign mem_tx_strobe = w_strobe;
    assign mem_tx_write  = 1'b0;
    assign mem_tx_addr   = r_pc;

endmodule
